sq_rom_top: RTL and testbench

- Synchronous 16-entry x 8-bit lookup ROM with a registered read port.
- Each entry holds the square of its address: entry i = i*i.
- Used as a small constant table; the address is applied each cycle and the data is read back one clock later.
- Contents are fixed at elaboration. There is no write path.

---
 rtl/sq_rom_top.sv | 68 ++++++
 tb/tb_sq_rom_top.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/sq_rom_top.sv
// 16-entry square-table ROM with a registered read port (entry i = i*i).
// Define ROM_PARITY_EN to add a registered even-parity output q_par.
module sq_rom_top #(
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned DATA_W = 8,
   parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic [ADDR_W-1:0] a,
   output logic [DATA_W-1:0] q,
   output logic              valid
`ifdef ROM_PARITY_EN
   ,
   output logic              q_par
`endif
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   function automatic logic [DATA_W-1:0] sq_entry(input logic [ADDR_W-1:0] addr);
      logic [2*ADDR_W-1:0] ext;
      logic [2*ADDR_W-1:0] prod;
      ext  = {{ADDR_W{1'b0}}, addr};
      prod = ext * ext;
      return DATA_W'(prod);
   endfunction

   logic [DATA_W-1:0] rom [DEPTH];

   for (genvar i = 0; i < DEPTH; i++) begin : g_rom
      assign rom[i] = sq_entry(ADDR_W'(i));
   end

   logic [DATA_W-1:0] rd_data;

   // An unknown address reads as RESET_VAL rather than letting X reach q.
   always_comb begin
      rd_data = RESET_VAL;
      if (!$isunknown(a)) begin
         rd_data = rom[a];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q     <= RESET_VAL;
         valid <= 1'b0;
      end else begin
         valid <= en;
         if (en) begin
            q <= rd_data;
         end
      end
   end

`ifdef ROM_PARITY_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_par <= ^RESET_VAL;
      end else if (en) begin
         q_par <= ^rd_data;
      end
   end
`endif

endmodule

// File: tb/tb_sq_rom_top.sv
// Scoreboard bench for sq_rom_top: the driver queues expected results at each
// capture edge and a monitor compares them on the following falling edge.
module tb_sq_rom_top;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic [3:0] a;
   logic [7:0] q;
   logic       valid;
`ifdef ROM_PARITY_EN
   logic       q_par;
`endif

   sq_rom_top dut (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .a     (a),
      .q     (q),
      .valid (valid)
`ifdef ROM_PARITY_EN
      ,
      .q_par (q_par)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] q;
      logic       v;
   } exp_t;

   exp_t       sb[$];
   int         n_checks = 0;
   int         n_pass   = 0;
   logic [7:0] exp_q    = 8'h00;
   logic [7:0] sq_tab [16] = '{8'h00, 8'h01, 8'h04, 8'h09, 8'h10, 8'h19, 8'h24, 8'h31,
                               8'h40, 8'h51, 8'h64, 8'h79, 8'h90, 8'hA9, 8'hC4, 8'hE1};

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Monitor: one queued expectation per falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("q", q, e.q);
            check("valid", {7'b0, valid}, {7'b0, e.v});
`ifdef ROM_PARITY_EN
            check("q_par", {7'b0, q_par}, {7'b0, ^e.q});
`endif
         end
      end
   end

   // Drive inputs, let the capture edge happen, queue the expected result.
   task automatic apply(input logic e_in, input logic [3:0] a_in, input logic [7:0] x_val);
      en = e_in;
      a  = a_in;
      @(posedge clk);
      if (e_in) exp_q = ($isunknown(a_in)) ? x_val : sq_tab[a_in];
      sb.push_back('{q: exp_q, v: e_in});
      #2;
   endtask

   task automatic async_reset_pulse(input string name);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check({name, "_q"}, q, 8'h00);
      check({name, "_valid"}, {7'b0, valid}, 8'h00);
      rst_n = 1'b1;
      exp_q = 8'h00;
   endtask

   initial begin
      rst_n = 1'b0;
      en    = 1'b1;
      a     = 4'd5;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_hold_q", q, 8'h00);
         check("rst_hold_valid", {7'b0, valid}, 8'h00);
      end
      #2 rst_n = 1'b1;

      // Read 5, then assert reset with no clock edge.
      apply(1'b1, 4'd5, 8'h00);
      async_reset_pulse("rst_async");

      // Full sweep.
      for (int i = 0; i < 16; i++) apply(1'b1, 4'(i), 8'h00);
      // Wrap boundary.
      apply(1'b1, 4'd15, 8'h00);
      apply(1'b1, 4'd0, 8'h00);

      // Hold: q must keep 90 while disabled.
      apply(1'b1, 4'd12, 8'h00);
      for (int i = 0; i < 3; i++) apply(1'b0, 4'd3, 8'h00);
      apply(1'b1, 4'd3, 8'h00);

      // Unknown address reads as the reset value.
      apply(1'b1, 4'bxx1x, 8'h00);

      // Mid-stream reset at a = 7, then resume at 8.
      for (int i = 0; i < 8; i++) apply(1'b1, 4'(i), 8'h00);
      async_reset_pulse("rst_mid");
      apply(1'b1, 4'd8, 8'h00);
      apply(1'b1, 4'd9, 8'h00);

      // Parity-relevant vectors (parity also checked on every read when enabled).
      apply(1'b1, 4'd3, 8'h00);
      apply(1'b1, 4'd7, 8'h00);
      apply(1'b1, 4'd13, 8'h00);
      apply(1'b0, 4'd0, 8'h00);

      repeat (3) @(negedge clk);
      #1;
      check("sb_drained", 8'(sb.size()), 8'h00);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Safety bound on total run time.
   initial begin
      #20000;
      $display("FAIL timeout: got running expected finished at %0t", $time);
      $fatal(1);
   end

endmodule
